pcm_formatter: RTL and testbench
================================

# pcm_formatter

Downstream consumer of the overlap stage. Accepts 65-bit signed fixed-point PCM samples from the overlap output handshake, then rounds and saturates each one to 16-bit PCM. Results go through a small FIFO and out on a valid/ready interface, with a frame-end marker and a saturation statistic. Sits between overlap and the audio output/serializer.

## Interface
- FRAC_BITS, 32, fractional bits of input sample (1..48)
- DEPTH, 8, FIFO depth in samples (power of 2, ≥2)
- FRAME_LEN, 1024, output samples per frame (≥2)

- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- in_pcmfmt_pcmSample  input  65  signed two's-complement sample from overlap
- in_pcmfmt_valid  input  1  upstream sample valid
- in_pcmfmt_ready  output  1  block can accept a sample
- out_pcmfmt_pcmSample  output  16  signed 16-bit PCM
- out_pcmfmt_last  output  1  current output is last sample of frame
- out_pcmfmt_valid  output  1  output sample valid
- out_pcmfmt_ready  input  1  downstream accepts
- sat_count  output  16  number of saturated samples since reset

## Operation
- Transfer on any port = valid && ready on a rising edge; valid must not depend on ready.
- Conversion is combinational on the input, computed at 66 bits to avoid overflow:
  - r = (x + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift); this rounds half toward +inf.
  - r > 32767 → 32767, sat flag = 1.
  - r < −32768 → −32768, sat flag = 1.
  - Otherwise r[15:0], sat flag = 0.
- FIFO: DEPTH entries of 16 bits, with write/read pointers of log2(DEPTH) bits plus count.
  - Accepted input writes the converted sample at the write pointer.
  - Output accept advances the read pointer.
  - Pointers wrap modulo DEPTH.
- in_pcmfmt_ready = (count != DEPTH); it is derived from the registered count only.
- out_pcmfmt_valid = (count != 0); out_pcmfmt_pcmSample = FIFO head.
- Frame counter (0..FRAME_LEN-1):
  - Increments on each output accept and wraps to 0 after FRAME_LEN-1.
  - out_pcmfmt_last = valid && (frame counter == FRAME_LEN-1).
- sat_count increments on each accepted input with sat flag = 1, and saturates at 65535 (no wrap).
- Reset (asserted at any time, including mid-frame or with FIFO non-empty):
  - FIFO emptied, pointers, count, frame counter and sat_count = 0.
  - in_pcmfmt_ready = 0 while reset is low, 1 from the first edge after release.
  - out_pcmfmt_valid = 0, out_pcmfmt_last = 0, out_pcmfmt_pcmSample = 0.

## Timing
- Latency: a sample accepted at edge k with an empty FIFO is presented with out_pcmfmt_valid = 1 in the cycle after edge k (1 cycle).
- Throughput: 1 sample/cycle when downstream ready is held high.
- Simultaneous push and pop:
  - Count is unchanged; both pointers advance.
  - This is legal at any non-empty, non-full count.
  - With an empty FIFO, a pop is impossible (valid = 0); the push alone occurs.
- Full FIFO:
  - in_pcmfmt_ready = 0 even if a pop happens in the same cycle; the freed slot is visible the next cycle.
- Empty FIFO: out_pcmfmt_valid = 0; out_pcmfmt_pcmSample holds its last value (don't-care, not checked).
- Backpressure: while out_pcmfmt_valid && !out_pcmfmt_ready, out_pcmfmt_pcmSample and out_pcmfmt_last are stable.

## Structure
- Package pcm_formatter_pkg:
  - PCM_W = 16, IN_W = 65.
  - PCM_MAX = 16'sh7FFF, PCM_MIN = 16'sh8000.
  - typedef pcm_t (logic signed [15:0]).
  - Rounding/saturation function sat_round(x, frac_bits) returning {sat, pcm_t}; shared with the reference model.
- Sub-module pcm_fifo (parameters: WIDTH, DEPTH):
  - Synchronous FIFO, async active-low reset.
  - Ports: push, pop, din, dout, full, empty, count.
- Top level: conversion, handshake glue, frame counter, sat_count.

## Test plan
- Rounding, FRAC_BITS = 32:
  - Input 1.5·2^32 → out 2.
  - Input −1.5·2^32 → out −1.
  - Input 0x0_7FFF_FFFF (≈0.5−ε) → out 0.
  - sat_count stays 0.
- Saturation:
  - Input 40000·2^32 → 32767; input −40000·2^32 → −32768.
  - Input 32767·2^32 → 32767 with no saturation count.
  - Result: sat_count = 2.
- Backpressure/full:
  - Hold out ready = 0 and drive 10 valid inputs: exactly 8 accepted, then in_ready = 0.
  - Release out ready: 8 outputs in order, and in_ready = 1 the cycle after the first pop.
- Streaming: in valid and out ready both held high for 2048 samples.
  - One output per cycle after 1-cycle latency.
  - out_last high on output indices 1023 and 2047 only.
- Reset mid-operation:
  - Assert reset with 5 samples queued, frame counter = 300 and sat_count = 3.
  - All outputs go to 0 immediately (asynchronous).
  - After release, the next frame's out_last occurs on the 1024th output.
- sat_count ceiling: feed 65537 saturating samples → sat_count = 65535.

Source files
------------

// File: rtl/pcm_formatter_pkg.sv
// Shared definitions for the PCM formatter: sample widths, PCM limits and
// the round-half-up / saturate conversion from wide fixed point to 16-bit PCM.
package pcm_formatter_pkg;

  localparam int PCM_W = 16;
  localparam int IN_W  = 65;

  typedef logic signed [PCM_W-1:0] pcm_t;

  localparam pcm_t PCM_MAX = 16'sh7FFF;
  localparam pcm_t PCM_MIN = 16'sh8000;

  // Conversion result: saturation flag plus the PCM value.
  typedef struct packed {
    logic sat;
    pcm_t pcm;
  } conv_t;

  // Add half an LSB of the output and shift arithmetically (round half toward
  // +inf), then clamp to the 16-bit range. One extra bit of headroom keeps the
  // rounding add from overflowing at the extreme input values.
  function automatic conv_t sat_round(input logic signed [IN_W-1:0] x,
                                      input int unsigned           frac_bits);
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] half;
    logic signed [IN_W:0] r;
    conv_t                res;
    ext  = {x[IN_W-1], x};
    half = 66'sd1 <<< (frac_bits - 1);
    r    = (ext + half) >>> frac_bits;
    if (r > 66'sd32767) begin
      res.sat = 1'b1;
      res.pcm = PCM_MAX;
    end else if (r < -66'sd32768) begin
      res.sat = 1'b1;
      res.pcm = PCM_MIN;
    end else begin
      res.sat = 1'b0;
      res.pcm = r[PCM_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/pcm_fifo.sv
// Synchronous FIFO with registered occupancy count.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push_i / din_i      write request and data (ignored when full)
//   pop_i / dout_o      read request (ignored when empty) and head data
//   full_o, empty_o     status derived from the registered count
//   count_o             number of stored entries (0..DEPTH)
module pcm_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointer wrap is the natural binary overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; emptiness is tracked by the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/pcm_formatter.sv
// PCM formatter: converts 65-bit signed fixed-point samples to 16-bit PCM
// (round half up, saturate), buffers them in a small FIFO and presents them on
// a valid/ready output with a frame-end marker and a saturation counter.
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   in_pcmfmt_pcmSample/valid/ready  input sample handshake
//   out_pcmfmt_pcmSample/last/valid/ready  output PCM handshake
//   sat_count                        saturated samples since reset (sticks at max)
module pcm_formatter
  import pcm_formatter_pkg::*;
#(
  parameter int FRAC_BITS = 32,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] in_pcmfmt_pcmSample,
  input  logic                   in_pcmfmt_valid,
  output logic                   in_pcmfmt_ready,
  output logic signed [PCM_W-1:0] out_pcmfmt_pcmSample,
  output logic                   out_pcmfmt_last,
  output logic                   out_pcmfmt_valid,
  input  logic                   out_pcmfmt_ready,
  output logic [15:0]            sat_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int FC_W  = $clog2(FRAME_LEN);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_LEN - 1);

  conv_t              conv;
  logic               push, pop;
  logic [PCM_W-1:0]   fifo_dout;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  logic [FC_W-1:0]    fc_q, fc_d;
  logic [15:0]        sat_q, sat_d;
  logic               rdy_en_q;

  assign conv = sat_round(in_pcmfmt_pcmSample, FRAC_BITS);

  // Holds input ready low while in reset and until the first edge afterwards.
  assign in_pcmfmt_ready  = rdy_en_q && !fifo_full;
  assign out_pcmfmt_valid = (fifo_count != '0);
  assign push = in_pcmfmt_valid && in_pcmfmt_ready;
  assign pop  = out_pcmfmt_valid && out_pcmfmt_ready;

  pcm_fifo #(
    .WIDTH (PCM_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (conv.pcm),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Force zero while empty so reset clears the output sample too.
  assign out_pcmfmt_pcmSample = fifo_empty ? '0 : pcm_t'(fifo_dout);
  assign out_pcmfmt_last      = out_pcmfmt_valid && (fc_q == FC_LAST);
  assign sat_count            = sat_q;

  always_comb begin
    fc_d  = fc_q;
    sat_d = sat_q;
    if (pop) fc_d = (fc_q == FC_LAST) ? '0 : fc_q + FC_W'(1);
    if (push && conv.sat && (sat_q != 16'hFFFF)) sat_d = sat_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fc_q     <= '0;
      sat_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      fc_q     <= fc_d;
      sat_q    <= sat_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcm_formatter.sv
// Randomized self-checking bench for pcm_formatter with a queue-based model.
module tb_pcm_formatter;

  localparam int FRAC_BITS = 32;
  localparam int DEPTH     = 8;
  localparam int FRAME_LEN = 1024;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [64:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] out_data;
  logic               out_last;
  logic               out_valid;
  logic               out_ready;
  logic [15:0]        sat_count;

  always #5 clk = ~clk;

  pcm_formatter #(
    .FRAC_BITS (FRAC_BITS),
    .DEPTH     (DEPTH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_pcmfmt_pcmSample  (in_data),
    .in_pcmfmt_valid      (in_valid),
    .in_pcmfmt_ready      (in_ready),
    .out_pcmfmt_pcmSample (out_data),
    .out_pcmfmt_last      (out_last),
    .out_pcmfmt_valid     (out_valid),
    .out_pcmfmt_ready     (out_ready),
    .sat_count            (sat_count)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic signed [15:0] q[$];
  logic signed [15:0] out_log[$];
  logic signed [64:0] dirq[$];
  int                 last_log[$];
  int                 fidx, satcnt, out_idx, n_acc, dut_acc, mode, last_cycles;
  bit                 rst_hold;

  function automatic logic signed [15:0] ref_conv(input logic signed [64:0] x, output bit s);
    logic signed [127:0] w;
    w = x;
    w = (w + (128'sd1 <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
    if (w > 32767)  begin s = 1'b1; return 16'sh7FFF; end
    if (w < -32768) begin s = 1'b1; return 16'sh8000; end
    s = 1'b0;
    return w[15:0];
  endfunction

  function automatic logic signed [64:0] gen();
    logic signed [64:0] v;
    if (dirq.size() != 0) return dirq.pop_front();
    v = 65'({$urandom, $urandom, $urandom});
    case (mode)
      1:       v[63] = ~v[64];
      2:       v = v >>> 18;
      default: v = v >>> $urandom_range(0, 40);
    endcase
    return v;
  endfunction

  task automatic model_clear();
    q.delete();
    fidx = 0; satcnt = 0;
  endtask

  // Check outputs against the model, advance one clock, update the model.
  task automatic step();
    bit mrdy, ain, aout, s;
    logic signed [15:0] p;
    mrdy = !rst_hold && (q.size() != DEPTH);
    check("in_ready", in_ready, mrdy);
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_data", out_data, q[0]);
      check("out_last", out_last, fidx == FRAME_LEN - 1);
    end
    check("sat_count", sat_count, satcnt);
    ain  = in_valid && mrdy;
    aout = out_ready && (q.size() != 0);
    if (in_valid && in_ready) dut_acc++;
    if (aout) begin
      if (out_last) last_log.push_back(out_idx);
      out_log.push_back(out_data);
      out_idx++;
      void'(q.pop_front());
      fidx = (fidx + 1) % FRAME_LEN;
    end
    if (ain) begin
      p = ref_conv(in_data, s);
      q.push_back(p);
      if (s && satcnt != 65535) satcnt++;
      n_acc++;
    end
    @(posedge clk);
    #1;
    rst_hold = 1'b0;
    if (ain) in_data = gen();
  endtask

  task automatic run_acc(input int n, input int budget);
    int target, c;
    target = n_acc + n;
    c = 0;
    while (n_acc < target && c < budget) begin
      step();
      c++;
    end
    last_cycles = c;
    check("accept_timeout", n_acc >= target, 1);
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (q.size() != 0 && c < budget) begin
      step();
      c++;
    end
    check("drain_timeout", q.size() == 0, 1);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_sat_count", sat_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    rst_hold = 1'b1;
    in_valid = 1'b0;
    step();
    out_idx = 0;
    last_log.delete();
    out_log.delete();
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0; mode = 0;
    n_acc = 0; dut_acc = 0; out_idx = 0; rst_hold = 1'b1;
    model_clear();
    #2;
    do_reset();

    // Rounding cases
    dirq.push_back(65'sh1_8000_0000);
    dirq.push_back(-65'sh1_8000_0000);
    dirq.push_back(65'sh0_7FFF_FFFF);
    in_data = gen(); in_valid = 1'b1; out_ready = 1'b1;
    run_acc(3, 50);
    in_valid = 1'b0;
    drain(20);
    check("round_n", out_log.size(), 3);
    if (out_log.size() == 3) begin
      check("round_1p5", out_log[0], 64'(16'sd2));
      check("round_m1p5", out_log[1], 64'($signed(-16'sd1)));
      check("round_half_eps", out_log[2], 0);
    end
    check("round_sat_zero", sat_count, 0);

    // Saturation cases
    out_log.delete();
    dirq.push_back(65'sd40000 <<< 32);
    dirq.push_back(-(65'sd40000 <<< 32));
    dirq.push_back(65'sd32767 <<< 32);
    in_data = gen(); in_valid = 1'b1;
    run_acc(3, 50);
    in_valid = 1'b0;
    drain(20);
    check("sat_n", out_log.size(), 3);
    if (out_log.size() == 3) begin
      check("sat_pos", out_log[0], 64'(16'sh7FFF));
      check("sat_neg", out_log[1], 64'($signed(16'sh8000)));
      check("sat_edge", out_log[2], 64'(16'sh7FFF));
    end
    check("sat_count_2", sat_count, 2);

    // Backpressure / full FIFO
    mode = 0; out_ready = 1'b0; in_data = gen(); in_valid = 1'b1;
    dut_acc = 0;
    repeat (10) step();
    check("bp_accepted", dut_acc, 8);
    check("bp_in_ready_low", in_ready, 0);
    in_valid = 1'b0; out_ready = 1'b1; out_log.delete();
    drain(20);
    check("bp_outputs", out_log.size(), 8);

    // Streaming with frame markers
    do_reset();
    mode = 0; in_data = gen(); in_valid = 1'b1; out_ready = 1'b1;
    run_acc(2048, 2200);
    check("stream_cycles", last_cycles, 2048);
    in_valid = 1'b0;
    drain(20);
    check("stream_outputs", out_idx, 2048);
    check("stream_last_n", last_log.size(), 2);
    if (last_log.size() == 2) begin
      check("stream_last_0", last_log[0], 1023);
      check("stream_last_1", last_log[1], 2047);
    end

    // Reset mid-operation: frame counter 300, 5 queued, sat_count 3
    do_reset();
    mode = 2; in_data = gen(); in_valid = 1'b1; out_ready = 1'b1;
    run_acc(300, 400);
    in_valid = 1'b0;
    drain(20);
    out_ready = 1'b0;
    dirq.push_back(65'sd40000 <<< 32);
    dirq.push_back(-(65'sd40000 <<< 32));
    dirq.push_back(65'sd50000 <<< 32);
    dirq.push_back(65'sd5 <<< 32);
    dirq.push_back(65'sd7 <<< 32);
    in_data = gen(); in_valid = 1'b1;
    run_acc(5, 20);
    in_valid = 1'b0;
    step();
    check("pre_rst_sat", sat_count, 3);
    check("pre_rst_valid", out_valid, 1);
    do_reset();
    mode = 0; in_data = gen(); in_valid = 1'b1; out_ready = 1'b1;
    run_acc(1100, 1300);
    in_valid = 1'b0;
    drain(20);
    check("post_rst_last_n", last_log.size() >= 1, 1);
    if (last_log.size() >= 1) check("post_rst_last_pos", last_log[0], 1023);

    // sat_count ceiling
    do_reset();
    mode = 1; in_data = gen(); in_valid = 1'b1; out_ready = 1'b1;
    run_acc(65537, 66000);
    in_valid = 1'b0;
    drain(20);
    check("sat_ceiling", sat_count, 65535);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
